// File: rtl/nes_pad_reader.sv
// NES pad serial front end: polls the 4021 via latch/clock pins, returns an active-high button byte.
// Latency: buttons/valid update one cycle after DONE; frame = LATCH_CYCLES + 15*HALF_PERIOD + 1 cycles.
// No backpressure: valid is a one-cycle pulse; optional debounce via `define PAD_DEBOUNCE_EN.
module nes_pad_reader #(
    parameter int POLL_CYCLES  = 200000,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_PERIOD  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       valid
);

    localparam int PW     = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int PH_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int HW     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(LATCH_CYCLES - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] poll_cnt;
    logic          start;
    logic [HW-1:0] phase;
    logic [HW-1:0] phase_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic          capture;
    logic          commit;
    logic          sync_q1;
    logic          sd;
    logic [7:0]    raw;

    // Two-flop synchronizer for the asynchronous pad data line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sd      <= 1'b0;
        end else begin
            sync_q1 <= pad_data;
            sd      <= sync_q1;
        end
    end

    // Free-running poll counter; the wrap cycle kicks off a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    assign start = (poll_cnt == POLL_LAST);

    // FSM state, phase and bit counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    // Next-state logic; capture fires on the last cycle of each LOW half period
    always_comb begin
        state_nxt = state;
        phase_nxt = phase + HW'(1);
        bit_nxt   = bit_cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (start) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (phase == LATCH_LAST) begin
                    state_nxt = LOW;
                    phase_nxt = '0;
                    bit_nxt   = 3'd0;
                end
            end
            LOW: begin
                if (phase == HALF_LAST) begin
                    capture   = 1'b1;
                    phase_nxt = '0;
                    state_nxt = (bit_cnt == 3'd7) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (phase == HALF_LAST) begin
                    phase_nxt = '0;
                    bit_nxt   = bit_cnt + 3'd1;
                    state_nxt = LOW;
                end
            end
            DONE: begin
                phase_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                phase_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Raw shift capture: pad data is active low, store as pressed = 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw <= 8'h00;
        end else if (capture) begin
            raw[bit_cnt] <= ~sd;
        end
    end

`ifdef PAD_DEBOUNCE_EN
    logic [7:0] prev_raw;

    // Previous-frame raw byte; a commit needs two identical frames in a row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_raw <= 8'h00;
        end else if (state == DONE) begin
            prev_raw <= raw;
        end
    end

    assign commit = (state == DONE) && (raw == prev_raw);
`else
    assign commit = (state == DONE);
`endif

    // Registered pad pins decoded from the next state, so they are glitch-free and aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
        end else begin
            pad_latch <= (state_nxt == LATCH);
            pad_clk   <= (state_nxt == HIGH);
        end
    end

    // Button byte and its valid pulse, written together on a commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buttons <= 8'h00;
            valid   <= 1'b0;
        end else begin
            valid <= commit;
            if (commit) begin
                buttons <= raw;
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;

    localparam int POLL  = 200;
    localparam int LATCH = 4;
    localparam int HALF  = 4;
`ifdef PAD_DEBOUNCE_EN
    localparam int FIRST_VALID = 2 * POLL + LATCH + 15 * HALF + 1;
`else
    localparam int FIRST_VALID = POLL + LATCH + 15 * HALF + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic       valid;

    logic       ovr_en  = 1'b1;
    logic       ovr_val = 1'b0;
    logic [7:0] pad_btn = 8'h00;
    logic [7:0] sr      = 8'hFF;
    logic [7:0] prev_m  = 8'h00;

    logic [7:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int cyc        = 0;
    int latch_len  = 0;
    int clk_rises  = 0;
    bit first_latch = 1'b1;
    bit first_valid = 1'b1;
    logic prev_latch = 1'b0;
    logic prev_clk   = 1'b0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    nes_pad_reader #(
        .POLL_CYCLES (POLL),
        .LATCH_CYCLES(LATCH),
        .HALF_PERIOD (HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pad_data (pad_data),
        .pad_latch(pad_latch),
        .pad_clk  (pad_clk),
        .buttons  (buttons),
        .valid    (valid)
    );

    // Behavioural 4021: parallel load on latch, shift toward Q8 on clock rise, serial-in high
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) sr <= ~pad_btn;
        else           sr <= {1'b1, sr[7:1]};
    end

    assign pad_data = ovr_en ? ovr_val : sr[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: protocol timing and scoreboard comparison, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            cyc         = 0;
            first_latch = 1'b1;
            first_valid = 1'b1;
            prev_latch  = 1'b0;
            prev_clk    = 1'b0;
            prev_valid  = 1'b0;
            latch_len   = 0;
            clk_rises   = 0;
        end else begin
            cyc++;
            if (pad_latch || pad_clk)
                chk("no_overlap", {31'd0, pad_latch & pad_clk}, 32'd0);
            if (pad_latch && !prev_latch) begin
                if (first_latch) begin
                    chk("latch_start", cyc, POLL);
                    first_latch = 1'b0;
                end
                latch_len = 1;
                clk_rises = 0;
            end else if (pad_latch) begin
                latch_len++;
            end
            if (!pad_latch && prev_latch)
                chk("latch_len", latch_len, LATCH);
            if (pad_clk && !prev_clk)
                clk_rises++;
            if (valid) begin
                if (first_valid) begin
                    chk("valid_cycle", cyc, FIRST_VALID);
                    first_valid = 1'b0;
                end
                chk("valid_pulse", {31'd0, prev_valid}, 32'd0);
                chk("clk_rises", clk_rises, 7);
                chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    chk("buttons", {24'd0, buttons}, {24'd0, exp_q.pop_front()});
            end
            prev_latch = pad_latch;
            prev_clk   = pad_clk;
            prev_valid = valid;
        end
    end

    // Drive one frame's pad byte, predict the commit, then let the frame complete
    task automatic run_frame(input logic [7:0] b);
        bit got;
        pad_btn = b;
`ifdef PAD_DEBOUNCE_EN
        if (b == prev_m) exp_q.push_back(b);
        prev_m = b;
`else
        exp_q.push_back(b);
`endif
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (pad_latch) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_start", {31'd0, got}, 32'd1);
        repeat (100) @(posedge clk);
    endtask

    logic [7:0] frames[13] = '{8'h08, 8'h08, 8'h81, 8'h81, 8'hFF, 8'hFF,
                              8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h81, 8'h81};

    initial begin
        int  rises;
        logic pc;
        bit  got;

        // Reset held with a toggling data line: outputs must stay at reset values
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ovr_val = ~ovr_val;
        end
        chk("rst_latch",   {31'd0, pad_latch}, 32'd0);
        chk("rst_clk",     {31'd0, pad_clk},   32'd0);
        chk("rst_buttons", {24'd0, buttons},   32'd0);
        chk("rst_valid",   {31'd0, valid},     32'd0);
        ovr_en = 1'b0;

        @(negedge clk);
        #1 rst = 1'b1;
        foreach (frames[k]) run_frame(frames[k]);

        // Abort a frame during the HIGH phase of bit 3
        chk("sb_pre_abort", exp_q.size(), 0);
        pad_btn = 8'h55;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (pad_latch) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_frame_start", {31'd0, got}, 32'd1);
        rises = 0;
        pc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (pad_clk && !pc) rises++;
            pc = pad_clk;
            if (rises == 4) break;
        end
        chk("abort_reach",    rises, 4);
        chk("pre_abort_clk",  {31'd0, pad_clk}, 32'd1);
        chk("pre_abort_btn",  {24'd0, buttons}, 32'h81);
        rst = 1'b0;
        #1;
        chk("abort_clk",     {31'd0, pad_clk},   32'd0);
        chk("abort_latch",   {31'd0, pad_latch}, 32'd0);
        chk("abort_buttons", {24'd0, buttons},   32'd0);
        chk("abort_valid",   {31'd0, valid},     32'd0);
        exp_q.delete();
        prev_m = 8'h00;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        run_frame(8'h24);
        run_frame(8'h24);
        repeat (150) @(posedge clk);
        chk("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Serial front end for a physical NES controller. Periodically drives the pad's latch/clock pins, shifts in the eight button bits from the pad's 4021 shift register, and presents them as a parallel, active-high button byte. Sits directly upstream of the console core and feeds its `ctrl1[7:0]` input, replacing the static switch bank.

## Interface

Parameters:
- `POLL_CYCLES`, default 200000: `clk` cycles between frame starts; must be > `LATCH_CYCLES + 15*HALF_PERIOD + 4`.
- `LATCH_CYCLES`, default 600: cycles `pad_latch` is held high per frame.
- `HALF_PERIOD`, default 300: cycles per half period of `pad_clk`; must be ≥ 4.

Ports:
- `clk`: input, 1 bit. Clock. Same domain as the core's master clock.
- `rst`: input, 1 bit. Reset, asynchronous and active-low.
- `pad_data`: input, 1 bit. Serial data from the pad. Asynchronous to `clk`. Low means pressed.
- `pad_latch`: output, 1 bit. Parallel-load strobe to the pad. Active high.
- `pad_clk`: output, 1 bit. Shift clock to the pad. The pad shifts on its rising edge.
- `buttons`: output, 8 bits. Current button state, 1 = pressed. Bit order: [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right.
- `valid`: output, 1 bit. One-cycle pulse each time `buttons` is written.

## Operation

- `pad_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value `sd`.
- Free-running poll counter, 0..`POLL_CYCLES`-1.
  - Wraps to 0 unconditionally.
  - The wrap cycle raises `start`.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. Bit counter `bit` is 3 bits wide.
  - **IDLE:** `pad_latch`=0, `pad_clk`=0. On `start`, go to LATCH and clear the phase counter.
  - **LATCH:** `pad_latch`=1 for exactly `LATCH_CYCLES` cycles. Then go to LOW with `bit`=0.
  - **LOW:** `pad_clk`=0 for `HALF_PERIOD` cycles. In the last cycle, capture `raw[bit] <= ~sd`.
    - If `bit`==7, go to DONE.
    - Otherwise go to HIGH.
  - **HIGH:** `pad_clk`=1 for `HALF_PERIOD` cycles. Then `bit <= bit+1` and go to LOW.
  - **DONE:** one cycle. Commit `raw` to `buttons` according to the Configuration rules, pulse `valid` if committed, then go to IDLE.
- `start` arriving in any state other than IDLE is ignored. The parameter constraint guarantees this never happens.
- Exactly 7 rising edges of `pad_clk` occur per frame. The A bit is sampled before any clock edge.
- `buttons` holds its value between commits.

## Timing

- Reset values: `pad_latch`=0, `pad_clk`=0, `buttons`=8'h00, `valid`=0. Also reset to zero: FSM=IDLE, poll counter, `bit`, `raw`, synchronizer flops.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous). The next frame starts `POLL_CYCLES` cycles after `rst` deasserts.
- First frame: LATCH is entered on the cycle after the poll counter first wraps, i.e. cycle `POLL_CYCLES` after reset release.
- Frame length from LATCH entry to DONE exit: `LATCH_CYCLES + 15*HALF_PERIOD + 1` cycles.
- `pad_data` input-to-`sd` latency: 2 cycles. The sample point is `HALF_PERIOD`-1 ≥ 3 cycles after the preceding `pad_clk` edge or `pad_latch` fall, so the settled bit is captured.
- `valid` is registered. It is high during the cycle after DONE, the same cycle `buttons` shows the new value.
- `pad_latch` and `pad_clk` are registered outputs with no glitches. They are never high simultaneously.

## Configuration

- `PAD_DEBOUNCE_EN` defined:
  - DONE commits only if `raw` equals the raw byte captured in the previous frame.
  - The previous-frame register always updates in DONE and resets to 8'h00.
  - `valid` pulses only on a commit.
  - A button change is therefore visible two frames after it happens.
- `PAD_DEBOUNCE_EN` undefined:
  - Every DONE commits `raw` to `buttons` and pulses `valid`.
  - No previous-frame register is built.

## Test plan

Bench parameters: `POLL_CYCLES`=200, `LATCH_CYCLES`=4, `HALF_PERIOD`=4. A behavioural 4021 pad model loads on `pad_latch` high and shifts on the `pad_clk` rise.

- **Reset and idle.** Hold `rst`=0 and toggle `pad_data`. Required: all outputs at reset values. Release `rst`. Required: `pad_latch` rises at cycle 200, is high for 4 cycles, and 7 `pad_clk` pulses follow; `valid` rises at cycle 200+4+60+1.
- **Single button.** Pad presses Start only (serial stream 1,1,1,0,1,1,1,1). Required: `buttons`=8'h08 with the `valid` pulse (no debounce); after 2 frames with `PAD_DEBOUNCE_EN`.
- **Walking pattern.** Pad byte patterns A+Right, then all pressed, then none. Required: `buttons` = 8'h81, then 8'hFF, then 8'h00 on successive commits.
- **Debounce glitch.** With `PAD_DEBOUNCE_EN`, steady 8'h00; one frame reports B; then back to 8'h00. Required: `buttons` stays 8'h00 and no `valid` pulse occurs.
- **Mid-frame reset.** Assert `rst` during the HIGH phase of bit 3. Required: `pad_clk`/`pad_latch`/`buttons` go to 0 the same cycle. After release, a full clean frame starts 200 cycles later.
- **Protocol checks.** Assertion: `pad_latch`&`pad_clk` is never 1, and exactly 7 `pad_clk` rises occur per frame.
